// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: iterative radix-2 multiply/divide unit for the EXE stage.
// Runs signed/unsigned multiply (shift-add) and divide (restoring shift-subtract)
// on operand magnitudes, then applies sign correction before writing HI/LO.
//
// Ports:
//   clk, rst      pipeline clock, synchronous active-high reset
//   start         launch request, honoured only in IDLE
//   op            0 MULT, 1 MULTU, 2 DIV, 3 DIVU
//   val1, val2    multiplicand/dividend, multiplier/divisor (sampled with start)
//   flush         abort the in-flight operation
//   busy          high while not IDLE (stalls IF/ID/EXE)
//   done          one-cycle pulse when HI/LO carry a fresh result
//   hi, lo        MULT: product upper/lower half; DIV: remainder/quotient
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one multiply/divide bit per cycle, SIZE cycles
// FIX   | sign correction, HI/LO written on the way out
// DONE  | result valid, done pulse
module exe_muldiv_unit #(
    parameter int SIZE    = 32,
    parameter int OP_SIZE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OP_SIZE-1:0]  op,
    input  logic [SIZE-1:0]     val1,
    input  logic [SIZE-1:0]     val2,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic [SIZE-1:0]     hi,
    output logic [SIZE-1:0]     lo
);

    localparam int CNT_W = $clog2(SIZE + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                is_div;
    logic                q_neg;
    logic                r_neg;
    logic                div_zero;
    logic [SIZE-1:0]     b_mag;
    logic [2*SIZE-1:0]   acc;
    logic [CNT_W-1:0]    cnt;

    // operand decode at launch; op[0] clear means signed
    logic                a_neg;
    logic                b_neg;
    logic [SIZE-1:0]     a_mag;
    logic [SIZE-1:0]     b_mag_in;

    assign a_neg    = ~op[0] & val1[SIZE-1];
    assign b_neg    = ~op[0] & val2[SIZE-1];
    assign a_mag    = a_neg ? -val1 : val1;
    assign b_mag_in = b_neg ? -val2 : val2;

    // multiply step: acc = {partial product, remaining multiplier bits}
    logic [SIZE:0]       mul_sum;
    logic [2*SIZE-1:0]   mul_next;

    assign mul_sum  = {1'b0, acc[2*SIZE-1:SIZE]} + {1'b0, (acc[0] ? b_mag : {SIZE{1'b0}})};
    assign mul_next = {mul_sum, acc[SIZE-1:1]};

    // divide step: acc = {partial remainder, dividend bits shifting into quotient}
    logic [SIZE:0]       div_diff;
    logic [2*SIZE-1:0]   div_next;

    assign div_diff = acc[2*SIZE-1:SIZE-1] - {1'b0, b_mag};
    assign div_next = div_diff[SIZE] ? {acc[2*SIZE-2:0], 1'b0}
                                     : {div_diff[SIZE-1:0], acc[SIZE-2:0], 1'b1};

    // sign correction; divide-by-zero leaves |dividend| as remainder, so
    // re-applying the dividend sign returns the raw val1
    logic [2*SIZE-1:0]   prod_fix;
    logic [SIZE-1:0]     quo_fix;
    logic [SIZE-1:0]     rem_fix;

    assign prod_fix = q_neg ? -acc : acc;
    assign quo_fix  = div_zero ? {SIZE{1'b1}} : (q_neg ? -acc[SIZE-1:0] : acc[SIZE-1:0]);
    assign rem_fix  = r_neg ? -acc[2*SIZE-1:SIZE] : acc[2*SIZE-1:SIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: if (start && !flush) state_nxt = CALC;
            CALC: begin
                if (flush)                        state_nxt = IDLE;
                else if (cnt == CNT_W'(1))        state_nxt = FIX;
            end
            FIX:  state_nxt = flush ? IDLE : DONE;
            DONE: begin
                done      = ~flush;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_div   <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            b_mag    <= '0;
            acc      <= '0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        is_div   <= op[1];
                        q_neg    <= a_neg ^ b_neg;
                        r_neg    <= op[1] & a_neg;
                        div_zero <= op[1] & (val2 == '0);
                        b_mag    <= b_mag_in;
                        acc      <= {{SIZE{1'b0}}, a_mag};
                        cnt      <= CNT_W'(SIZE);
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*SIZE-1:SIZE];
                            lo <= prod_fix[SIZE-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
module tb_exe_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] val1;
    logic [31:0] val2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] last_res = '0;

    always #5 clk = ~clk;

    exe_muldiv_unit #(.SIZE(32), .OP_SIZE(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .val1  (val1),
        .val2  (val2),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // launches one op, optionally pulses a second start at CALC cycle mid_start,
    // then checks latency, busy width, HI/LO hold before done and the result
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int mid_start);
        int   cyc;
        int   busy_cyc;
        int   hold_err;
        logic seen;
        @(negedge clk);
        start = 1'b1; op = o; val1 = a; val2 = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); val1 = $urandom; val2 = $urandom;
        cyc = 1; busy_cyc = 0; hold_err = 0; seen = 1'b0;
        while (cyc <= 60 && !seen) begin
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if ({hi, lo} !== last_res) hold_err++;
                if (cyc == mid_start) begin
                    start = 1'b1; op = 2'd3; val1 = 32'd100; val2 = 32'd3;
                end
                @(negedge clk);
                start = 1'b0;
                cyc++;
            end
        end
        chk({tag, ".done_seen"}, 64'(seen), 64'd1);
        chk({tag, ".latency"}, 64'(cyc), 64'd34);
        chk({tag, ".busy_cycles"}, 64'(busy_cyc), 64'd34);
        chk({tag, ".hold"}, 64'(hold_err), 64'd0);
        chk({tag, ".result"}, {hi, lo}, exp);
        last_res = exp;
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int pulses = 0;
        int moved  = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) pulses++;
            if ({hi, lo} !== last_res) moved++;
        end
        chk({tag, ".no_done"}, 64'(pulses), 64'd0);
        chk({tag, ".hilo_kept"}, 64'(moved), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; op = 2'd1; val1 = 32'd5; val2 = 32'd5; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.hilo", {hi, lo}, 64'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset.no_launch", 64'(busy), 64'd0);

        run_op("multu_max_x2",  2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 0);
        run_op("mult_m3_x7",    2'd0, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 0);
        run_op("div_m7_2",      2'd2, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("divu_by_zero",  2'd3, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF, 0);
        run_op("div_overflow",  2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
        run_op("divu_max_16",   2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, 0);
        run_op("div_neg_by_0",  2'd2, 32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF, 0);
        run_op("mult_min_min",  2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
        run_op("mult_m1_m1",    2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0);
        run_op("div_7_m2",      2'd2, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0);
        run_op("divu_1000_7",   2'd3, 32'd1000,      32'd7,         64'h0000_0006_0000_008E, 0);
        run_op("restart_ign",   2'd1, 32'd5,         32'd6,         64'h0000_0000_0000_001E, 5);

        // flush at CALC cycle 10
        @(negedge clk);
        start = 1'b1; op = 2'd1; val1 = 32'h1234_5678; val2 = 32'h10;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush.busy_drop", 64'(busy), 64'd0);
        watch_no_done("flush", 40);

        // start and flush together in IDLE
        start = 1'b1; flush = 1'b1; op = 2'd0; val1 = 32'd9; val2 = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("idle_flush.no_launch", 64'(busy), 64'd0);
        watch_no_done("idle_flush", 40);

        run_op("after_flush",   2'd1, 32'd3,         32'd4,         64'h0000_0000_0000_000C, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
